// File: rtl/vram_arbiter.sv
// vram_arbiter: shares the single-port VRAM between video scanout fetch and the
// host/CPU port. Video has priority; the CPU is forced through after STARVE_MAX
// consecutive video grants. Owns the registered RAM address/write drive and
// routes read data back to the requester through a tag pipeline.
module vram_arbiter #(
   parameter int ADDR_W     = 15,
   parameter int DATA_W     = 8,
   parameter int RD_LAT     = 1,
   parameter int STARVE_MAX = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              vid_req,
   input  logic [ADDR_W-1:0] vid_addr,
   output logic              vid_ack,
   output logic              vid_rvalid,
   output logic [DATA_W-1:0] vid_rdata,
   input  logic              cpu_req,
   input  logic              cpu_we,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [DATA_W-1:0] cpu_wdata,
   output logic              cpu_ack,
   output logic              cpu_rvalid,
   output logic [DATA_W-1:0] cpu_rdata,
   output logic [ADDR_W-1:0] ram_addr,
   output logic              ram_we,
   output logic [DATA_W-1:0] ram_wdata,
   input  logic [DATA_W-1:0] ram_rdata
);

   // Starve limit narrowed to the counter width (STARVE_MAX is 1..15).
   localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

   // Tag layout {owner, is_read}; owner 0 = video, 1 = CPU.
   localparam logic [1:0] TAG_IDLE   = 2'b00;
   localparam logic [1:0] TAG_VID_RD = 2'b01;
   localparam logic [1:0] TAG_CPU_WR = 2'b10;
   localparam logic [1:0] TAG_CPU_RD = 2'b11;

   logic [3:0]              starve_r;
   logic                    force_s;
   logic                    vid_grant_s;
   logic                    cpu_grant_s;
   logic [1:0]              new_tag_s;
   logic [1:0]              tail_tag_s;
   logic [RD_LAT:0][1:0]    tag_pipe_r;
   logic [ADDR_W-1:0]       ram_addr_r;
   logic                    ram_we_r;
   logic [DATA_W-1:0]       ram_wdata_r;
   logic                    vid_rvalid_r;
   logic [DATA_W-1:0]       vid_rdata_r;
   logic                    cpu_rvalid_r;
   logic [DATA_W-1:0]       cpu_rdata_r;

   // Grant decision: video first unless the CPU has waited out its starve budget.
   always_comb begin
      force_s     = cpu_req && (starve_r == STARVE_LIM);
      vid_grant_s = vid_req && !force_s && !reset;
      cpu_grant_s = cpu_req && !vid_grant_s && !reset;
   end

   // Tag for the access issued this cycle; idle cycles carry a non-read tag.
   always_comb begin
      new_tag_s = TAG_IDLE;
      if (vid_grant_s) begin
         new_tag_s = TAG_VID_RD;
      end else if (cpu_grant_s) begin
         new_tag_s = cpu_we ? TAG_CPU_WR : TAG_CPU_RD;
      end else begin
         new_tag_s = TAG_IDLE;
      end
   end

   assign tail_tag_s = tag_pipe_r[RD_LAT];

   // Starve counter: counts video wins while the CPU waits, saturating at the limit.
   always_ff @(posedge clk) begin
      if (reset) begin
         starve_r <= 4'd0;
      end else if (!cpu_req || cpu_grant_s) begin
         starve_r <= 4'd0;
      end else if (vid_grant_s && (starve_r != STARVE_LIM)) begin
         starve_r <= starve_r + 4'd1;
      end else begin
         starve_r <= starve_r;
      end
   end

   // RAM command register: load the granted request; idle cycles only drop write-enable.
   always_ff @(posedge clk) begin
      if (reset) begin
         ram_addr_r  <= {ADDR_W{1'b0}};
         ram_we_r    <= 1'b0;
         ram_wdata_r <= {DATA_W{1'b0}};
      end else if (vid_grant_s) begin
         ram_addr_r  <= vid_addr;
         ram_we_r    <= 1'b0;
      end else if (cpu_grant_s) begin
         ram_addr_r  <= cpu_addr;
         ram_we_r    <= cpu_we;
         ram_wdata_r <= cpu_wdata;
      end else begin
         ram_we_r    <= 1'b0;
      end
   end

   // Tag pipe: RD_LAT+1 stages so the tail lines up with valid ram_rdata.
   always_ff @(posedge clk) begin
      if (reset) begin
         tag_pipe_r <= '{default: TAG_IDLE};
      end else begin
         tag_pipe_r <= {tag_pipe_r[RD_LAT-1:0], new_tag_s};
      end
   end

   // Read return: capture data for the tail tag's owner and pulse its rvalid.
   always_ff @(posedge clk) begin
      if (reset) begin
         vid_rvalid_r <= 1'b0;
         vid_rdata_r  <= {DATA_W{1'b0}};
         cpu_rvalid_r <= 1'b0;
         cpu_rdata_r  <= {DATA_W{1'b0}};
      end else begin
         vid_rvalid_r <= 1'b0;
         cpu_rvalid_r <= 1'b0;
         case (tail_tag_s)
            TAG_VID_RD: begin
               vid_rdata_r  <= ram_rdata;
               vid_rvalid_r <= 1'b1;
            end
            TAG_CPU_RD: begin
               cpu_rdata_r  <= ram_rdata;
               cpu_rvalid_r <= 1'b1;
            end
            default: begin
               vid_rdata_r <= vid_rdata_r;
               cpu_rdata_r <= cpu_rdata_r;
            end
         endcase
      end
   end

   assign vid_ack    = vid_grant_s;
   assign cpu_ack    = cpu_grant_s;
   assign ram_addr   = ram_addr_r;
   assign ram_we     = ram_we_r;
   assign ram_wdata  = ram_wdata_r;
   assign vid_rvalid = vid_rvalid_r;
   assign vid_rdata  = vid_rdata_r;
   assign cpu_rvalid = cpu_rvalid_r;
   assign cpu_rdata  = cpu_rdata_r;

endmodule
